sprite_pixel_reader: RTL and testbench
======================================

# sprite_pixel_reader

Consumer side of the sprite-request interface. Takes the per-pixel request (`ready`, `element`, `address`) from the sprite-selection logic, reads the addressed texel from the external sprite memory, resolves transparency against a frame-synchronous background colour and drives the 9-bit RGB value to the VGA output stage. It also counts opaque sprite pixels per frame for debug readout.

## Interface
- `ELEMENT`, 5: width of the element (sprite index) field.
- `ADDR_W`, 10: width of the texel address within one sprite.
- `COLOR_W`, 9: RGB width, packed as 3:3:3 (R in [8:6], G in [5:3], B in [2:0]).
- `TRANSPARENT`, 9'b111_000_111: texel value treated as transparent (magenta).
- `CNT_W`, 20: width of the pixel counters.

- `clk`  in  1  system/pixel clock; one clock, all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `ready`  in  1  request valid this cycle.
- `element`  in  ELEMENT  sprite index.
- `address`  in  ADDR_W  texel address inside the sprite.
- `video_on`  in  1  active-video flag from the VGA sync block, aligned with the request.
- `frame_start`  in  1  one-cycle pulse at the first pixel of each frame.
- `mem_en`  out  1  sprite memory read enable.
- `mem_addr`  out  ELEMENT+ADDR_W  `{element, address}`.
- `mem_rdata`  in  COLOR_W  texel; valid one cycle after `mem_en`, because the RAM has a registered output.
- `bg_wr_valid`  in  1  background colour write request.
- `bg_wr_data`  in  COLOR_W  new background colour.
- `bg_wr_ready`  out  1  write accepted when high together with `bg_wr_valid`.
- `rgb`  out  COLOR_W  pixel colour.
- `rgb_valid`  out  1  delayed copy of `video_on`.
- `drawn_last`  out  CNT_W  opaque sprite pixels counted in the previous frame.

## Operation
- Stage 0, at edge k: register `mem_en <= ready & video_on` and `mem_addr <= {element, address}`. `video_on` enters a 2-deep delay line.
- Stage 1, at edge k+1: the RAM presents `mem_rdata`. `mem_en` is delayed one stage as `hit`.
- Stage 2, at edge k+2, output register:
  - If the delayed `video_on` is 0, `rgb = 0`.
  - Otherwise, if `hit` is set and `mem_rdata != TRANSPARENT`, `rgb = mem_rdata`.
  - Otherwise `rgb = bg_active`.
  - `rgb_valid` follows the delayed `video_on`.
- Background colour uses two registers, `bg_active` and `bg_shadow`, plus a `pending` flag:
  - `bg_wr_ready = !pending`.
  - On accept: `bg_shadow <= bg_wr_data`, `pending <= 1`.
  - On `frame_start` with `pending` set: `bg_active <= bg_shadow`, `pending <= 0`.
  - Accept in the same cycle as `frame_start` while `pending = 0`: the value becomes pending and is applied at the next `frame_start`.
- Counter `drawn_cnt` increments whenever stage 2 outputs an opaque sprite pixel. It saturates at all-ones.
- On `frame_start`:
  - `drawn_last <= drawn_cnt`, where the value includes an opaque pixel output in that same cycle.
  - `drawn_cnt <= 0`.
  - Pixels still in flight in the pipeline are counted in the new frame.

## Timing
- Latency: a request sampled at edge k appears on `rgb`/`rgb_valid` after edge k+2, i.e. 2 cycles.
- Throughput: one pixel per cycle. No stalls and no backpressure on `ready`.
- `ready` while `video_on = 0` is ignored: no `mem_en` and no count.
- Reset values, applied asynchronously, all outputs and state:
  - `mem_en = 0`, `mem_addr = 0`
  - `rgb = 0`, `rgb_valid = 0`
  - `bg_active = 0`, `bg_shadow = 0`, `pending = 0`, so `bg_wr_ready = 1`
  - `drawn_cnt = 0`, `drawn_last = 0`, delay lines = 0
- Reset mid-frame: in-flight pixels are discarded. Output is black until new requests traverse the pipeline.

## Structure
- Shared video package holds:
  - `COLOR_W` and the RGB 3:3:3 field positions;
  - the `TRANSPARENT` constant;
  - sprite element/address widths, which must be shared with the sprite-selection logic.
- One sub-module, `bg_color_reg`, covers the shadow/active registers, `pending` and the handshake. The pipeline and counter stay in the top module.

## Test plan
- Reset released; `video_on=1`, `ready=1`, element 4, address 10'h015, RAM returns 9'h1C0 -> `mem_addr = 15'h1015` after 1 edge; `rgb = 9'h1C0`, `rgb_valid = 1` after 2 edges.
- Same request with RAM returning 9'h1C7 (transparent), `bg_active = 9'h007` -> `rgb = 9'h007`.
- `video_on=0` with `ready=1` -> `mem_en = 0`; 2 cycles later `rgb = 0`, `rgb_valid = 0`; count unchanged.
- Write 9'h038 mid-frame -> `bg_wr_ready` drops the next cycle. A second write is held off. Background stays at its old value until `frame_start`, then becomes 9'h038 and `bg_wr_ready = 1`.
- 100 opaque pixels then `frame_start` -> `drawn_last = 100`, `drawn_cnt = 0`. With `frame_start` coincident with an opaque output -> `drawn_last = 101`.
- Assert `reset` with a pixel in flight -> `rgb`, `rgb_valid`, `mem_en` are 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/sprite_pixel_reader_pkg.sv
// Shared video definitions: colour format, transparency key and the sprite
// element/address widths that must match the sprite-selection logic.
package sprite_pixel_reader_pkg;

  localparam int unsigned ELEMENT    = 5;
  localparam int unsigned ADDR_W     = 10;
  localparam int unsigned MEM_ADDR_W = ELEMENT + ADDR_W;
  localparam int unsigned COLOR_W    = 9;
  localparam int unsigned CH_W       = 3;
  localparam int unsigned CNT_W      = 20;

  localparam logic [COLOR_W-1:0] TRANSPARENT = 9'b111_000_111;

  // RGB 3:3:3, R in [8:6], G in [5:3], B in [2:0]
  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } rgb_t;

  typedef struct packed {
    logic [ELEMENT-1:0] element;
    logic [ADDR_W-1:0]  address;
  } sprite_addr_t;

  function automatic logic is_transparent(input logic [COLOR_W-1:0] texel);
    return texel == TRANSPARENT;
  endfunction

endpackage

// File: rtl/bg_color_reg.sv
// Frame-synchronous background colour: writes land in a shadow register and
// only become active at the next frame start, so a frame never changes mid-way.
module bg_color_reg
  import sprite_pixel_reader_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               wr_valid_i,
  input  logic [COLOR_W-1:0] wr_data_i,
  input  logic               frame_start_i,
  output logic               wr_ready_o,
  output logic [COLOR_W-1:0] bg_active_o
);

  logic               pending_q, pending_d;
  logic [COLOR_W-1:0] shadow_q, shadow_d;
  logic [COLOR_W-1:0] active_q, active_d;
  logic               accept;

  // Accept and apply are mutually exclusive because accept needs !pending.
  always_comb begin
    accept    = wr_valid_i & ~pending_q;
    pending_d = pending_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    if (frame_start_i && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (accept) begin
      shadow_d  = wr_data_i;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_q <= 1'b0;
      shadow_q  <= '0;
      active_q  <= '0;
    end else begin
      pending_q <= pending_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
    end
  end

  assign wr_ready_o  = ~pending_q;
  assign bg_active_o = active_q;

endmodule

// File: rtl/sprite_pixel_reader.sv
// Sprite texel fetch, transparency resolve against the background colour and
// per-frame opaque pixel counter; two-cycle pipeline, one pixel per clock.
module sprite_pixel_reader
  import sprite_pixel_reader_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ready,
  input  logic [ELEMENT-1:0]    element,
  input  logic [ADDR_W-1:0]     address,
  input  logic                  video_on,
  input  logic                  frame_start,
  output logic                  mem_en,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  input  logic [COLOR_W-1:0]    mem_rdata,
  input  logic                  bg_wr_valid,
  input  logic [COLOR_W-1:0]    bg_wr_data,
  output logic                  bg_wr_ready,
  output logic [COLOR_W-1:0]    rgb,
  output logic                  rgb_valid,
  output logic [CNT_W-1:0]      drawn_last
);

  logic               mem_en_q;
  sprite_addr_t       mem_addr_q;
  logic               hit_q;
  logic [1:0]         vid_q;
  logic [COLOR_W-1:0] rgb_q, rgb_d;
  logic               rgb_valid_q;
  logic [CNT_W-1:0]   drawn_cnt_q, drawn_cnt_d;
  logic [CNT_W-1:0]   drawn_last_q, drawn_last_d;
  logic [CNT_W-1:0]   cnt_inc;
  logic               opaque;
  logic [COLOR_W-1:0] bg_active;

  bg_color_reg u_bg (
    .clk_i         (clk),
    .rst_i         (reset),
    .wr_valid_i    (bg_wr_valid),
    .wr_data_i     (bg_wr_data),
    .frame_start_i (frame_start),
    .wr_ready_o    (bg_wr_ready),
    .bg_active_o   (bg_active)
  );

  // Stage 2 resolve; the frame-start snapshot includes this cycle's pixel.
  always_comb begin
    opaque  = vid_q[1] & hit_q & ~is_transparent(mem_rdata);
    rgb_d   = '0;
    if (vid_q[1]) begin
      rgb_d = opaque ? mem_rdata : bg_active;
    end
    cnt_inc = drawn_cnt_q;
    if (opaque && (drawn_cnt_q != '1)) begin
      cnt_inc = drawn_cnt_q + CNT_W'(1);
    end
    drawn_cnt_d  = cnt_inc;
    drawn_last_d = drawn_last_q;
    if (frame_start) begin
      drawn_cnt_d  = '0;
      drawn_last_d = cnt_inc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_en_q     <= 1'b0;
      mem_addr_q   <= '0;
      hit_q        <= 1'b0;
      vid_q        <= '0;
      rgb_q        <= '0;
      rgb_valid_q  <= 1'b0;
      drawn_cnt_q  <= '0;
      drawn_last_q <= '0;
    end else begin
      mem_en_q     <= ready & video_on;
      mem_addr_q   <= '{element: element, address: address};
      hit_q        <= mem_en_q;
      vid_q        <= {vid_q[0], video_on};
      rgb_q        <= rgb_d;
      rgb_valid_q  <= vid_q[1];
      drawn_cnt_q  <= drawn_cnt_d;
      drawn_last_q <= drawn_last_d;
    end
  end

  assign mem_en     = mem_en_q;
  assign mem_addr   = mem_addr_q;
  assign rgb        = rgb_q;
  assign rgb_valid  = rgb_valid_q;
  assign drawn_last = drawn_last_q;

endmodule

// File: tb/tb_sprite_pixel_reader.sv
// Directed bench for sprite_pixel_reader with a registered-output sprite RAM model.
module tb_sprite_pixel_reader;

  logic        clk;
  logic        reset;
  logic        ready;
  logic [4:0]  element;
  logic [9:0]  address;
  logic        video_on;
  logic        frame_start;
  logic        mem_en;
  logic [14:0] mem_addr;
  logic [8:0]  mem_rdata;
  logic        bg_wr_valid;
  logic [8:0]  bg_wr_data;
  logic        bg_wr_ready;
  logic [8:0]  rgb;
  logic        rgb_valid;
  logic [19:0] drawn_last;

  logic [8:0]  ram [32768];
  int          n_checks = 0;
  int          n_fail   = 0;

  sprite_pixel_reader dut (
    .clk         (clk),
    .reset       (reset),
    .ready       (ready),
    .element     (element),
    .address     (address),
    .video_on    (video_on),
    .frame_start (frame_start),
    .mem_en      (mem_en),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .bg_wr_valid (bg_wr_valid),
    .bg_wr_data  (bg_wr_data),
    .bg_wr_ready (bg_wr_ready),
    .rgb         (rgb),
    .rgb_valid   (rgb_valid),
    .drawn_last  (drawn_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sprite RAM with registered read data.
  always @(posedge clk) begin
    if (mem_en) mem_rdata <= ram[mem_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) ram[i] = 9'h000;
    ram[15'h1015] = 9'h1C0;
    ram[15'h0123] = 9'h0AA;
    mem_rdata   = 9'h000;
    reset       = 1'b1;
    ready       = 1'b0;
    element     = 5'd0;
    address     = 10'd0;
    video_on    = 1'b0;
    frame_start = 1'b0;
    bg_wr_valid = 1'b0;
    bg_wr_data  = 9'h000;

    tick();
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_rgb", 32'(rgb), 32'd0);
    check("rst_rgb_valid", 32'(rgb_valid), 32'd0);
    check("rst_bg_wr_ready", 32'(bg_wr_ready), 32'd1);
    check("rst_drawn_last", 32'(drawn_last), 32'd0);
    tick();
    reset = 1'b0;

    // Opaque texel
    video_on = 1'b1; ready = 1'b1; element = 5'd4; address = 10'h015;
    tick();
    check("op_mem_en", 32'(mem_en), 32'd1);
    check("op_mem_addr", 32'(mem_addr), 32'h1015);
    ready = 1'b0;
    ticks(2);
    check("op_rgb", 32'(rgb), 32'h1C0);
    check("op_rgb_valid", 32'(rgb_valid), 32'd1);

    // Load background 007, then a transparent texel
    bg_wr_valid = 1'b1; bg_wr_data = 9'h007;
    tick();
    bg_wr_valid = 1'b0;
    check("bg1_ready_low", 32'(bg_wr_ready), 32'd0);
    pulse_frame();
    check("bg1_ready_high", 32'(bg_wr_ready), 32'd1);
    check("frame1_drawn_last", 32'(drawn_last), 32'd1);
    ram[15'h1015] = 9'h1C7;
    ready = 1'b1;
    tick();
    ready = 1'b0;
    ticks(2);
    check("tr_rgb", 32'(rgb), 32'h007);
    check("tr_rgb_valid", 32'(rgb_valid), 32'd1);

    // ready ignored while blanking
    video_on = 1'b0; ready = 1'b1;
    tick();
    check("blank_mem_en", 32'(mem_en), 32'd0);
    ready = 1'b0;
    ticks(2);
    check("blank_rgb", 32'(rgb), 32'd0);
    check("blank_rgb_valid", 32'(rgb_valid), 32'd0);

    // Mid-frame background write held until frame_start
    video_on = 1'b1;
    bg_wr_valid = 1'b1; bg_wr_data = 9'h038;
    tick();
    check("bg2_ready_low", 32'(bg_wr_ready), 32'd0);
    bg_wr_data = 9'h1FF;
    ticks(2);
    check("bg2_held_off", 32'(bg_wr_ready), 32'd0);
    check("bg2_old_rgb", 32'(rgb), 32'h007);
    pulse_frame();
    bg_wr_valid = 1'b0;
    check("bg2_ready_high", 32'(bg_wr_ready), 32'd1);
    check("frame2_drawn_last", 32'(drawn_last), 32'd0);
    tick();
    check("bg2_new_rgb", 32'(rgb), 32'h038);

    // Write accepted on the same edge as frame_start waits a frame
    bg_wr_valid = 1'b1; bg_wr_data = 9'h155;
    pulse_frame();
    bg_wr_valid = 1'b0;
    check("bg3_pending", 32'(bg_wr_ready), 32'd0);
    tick();
    check("bg3_not_yet", 32'(rgb), 32'h038);
    pulse_frame();
    check("bg3_ready_high", 32'(bg_wr_ready), 32'd1);
    tick();
    check("bg3_applied", 32'(rgb), 32'h155);

    // 100 opaque pixels in one frame
    element = 5'd0; address = 10'h123; ready = 1'b1;
    ticks(100);
    ready = 1'b0;
    ticks(2);
    check("stream_rgb", 32'(rgb), 32'h0AA);
    pulse_frame();
    check("count_100", 32'(drawn_last), 32'd100);

    // 101st opaque pixel leaves stage 2 on the frame_start edge
    ready = 1'b1;
    ticks(101);
    ready = 1'b0;
    tick();
    pulse_frame();
    check("count_101", 32'(drawn_last), 32'd101);
    ticks(2);
    pulse_frame();
    check("count_cleared", 32'(drawn_last), 32'd0);

    // Pixels in flight at frame_start belong to the new frame
    ready = 1'b1;
    ticks(2);
    pulse_frame();
    ready = 1'b0;
    check("inflight_old", 32'(drawn_last), 32'd1);
    ticks(2);
    pulse_frame();
    check("inflight_new", 32'(drawn_last), 32'd2);

    // Asynchronous reset with pixels in flight
    ready = 1'b1;
    ticks(3);
    check("pre_rst_mem_en", 32'(mem_en), 32'd1);
    check("pre_rst_rgb", 32'(rgb), 32'h0AA);
    #2 reset = 1'b1;
    #1;
    check("arst_rgb", 32'(rgb), 32'd0);
    check("arst_rgb_valid", 32'(rgb_valid), 32'd0);
    check("arst_mem_en", 32'(mem_en), 32'd0);
    check("arst_drawn_last", 32'(drawn_last), 32'd0);
    ready = 1'b0;
    #2 reset = 1'b0;
    ticks(2);
    check("post_rst_valid0", 32'(rgb_valid), 32'd0);
    tick();
    check("post_rst_rgb", 32'(rgb), 32'd0);
    check("post_rst_valid1", 32'(rgb_valid), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
